// File: rtl/serial_frame_ctrl.sv
// Receive-side frame controller for a serial line feeding an external
// right shift register. Detects the start bit, enables the register for
// exactly DATA_W data bits, checks even parity and the stop bit, then holds
// the captured word under a valid/ready handshake.
//
// Parameter constraints:
//   DATA_W must match the width of the downstream shift register.
//   2**CNT_W >= DATA_W. bit_cnt reads DATA_W after the last data bit. If
//   DATA_W == 2**CNT_W, that value wraps to 0. The frame is still framed
//   correctly because the DATA exit compares against DATA_W-1.
module serial_frame_ctrl #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             ready_in,
  output logic             sh_en,
  output logic             frame_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_HOLD,
    S_BREAK
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             par, par_nxt;
  logic             perr_q, perr_nxt;
  logic             ferr_nxt;
  logic             ovr_nxt;

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      par       <= 1'b0;
      perr_q    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= cnt_nxt;
      par       <= par_nxt;
      perr_q    <= perr_nxt;
      frame_err <= ferr_nxt;
      overrun   <= ovr_nxt;
    end
  end

  // Next-state logic and datapath updates; every register holds by default.
  // frame_err defaults to 0, so it is high for exactly one cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    par_nxt   = par;
    perr_nxt  = perr_q;
    ferr_nxt  = 1'b0;
    ovr_nxt   = overrun;
    unique case (state)
      S_IDLE: begin
        if (!serial_in) begin
          state_nxt = S_DATA;
          cnt_nxt   = '0;
          par_nxt   = 1'b0;
        end
      end
      S_DATA: begin
        // The register samples this same bit, because sh_en is high here.
        cnt_nxt = bit_cnt + 1'b1;
        par_nxt = par ^ serial_in;
        if (bit_cnt == LAST_BIT) state_nxt = S_PARITY;
      end
      S_PARITY: begin
        // Even parity: XOR of the data bits and the parity bit must be 0.
        perr_nxt  = par ^ serial_in;
        state_nxt = S_STOP;
      end
      S_STOP: begin
        if (serial_in) begin
          state_nxt = S_HOLD;
        end else begin
          state_nxt = S_BREAK;
          ferr_nxt  = 1'b1;
        end
      end
      S_HOLD: begin
        if (ready_in) begin
          if (!serial_in) begin
            // The word is consumed on the same edge the next start bit
            // arrives, so no start bit is lost.
            state_nxt = S_DATA;
            cnt_nxt   = '0;
            par_nxt   = 1'b0;
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (!serial_in) begin
          // A start bit arrived while the word was still held. It is dropped.
          ovr_nxt = 1'b1;
        end
      end
      S_BREAK: begin
        if (serial_in) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs, decoded from the state register.
  always_comb begin
    sh_en       = (state == S_DATA);
    frame_valid = (state == S_HOLD);
    parity_err  = (state == S_HOLD) && perr_q;
    busy        = (state != S_IDLE);
  end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed bench for serial_frame_ctrl. It includes a behavioural model of
// the downstream right shift register, so the captured word can be compared
// against hand-computed values.
module tb_serial_frame_ctrl;

  localparam int DATA_W = 6;
  localparam int CNT_W  = 3;

  logic             clk;
  logic             rst;
  logic             serial_in;
  logic             ready_in;
  logic             sh_en;
  logic             frame_valid;
  logic             parity_err;
  logic             frame_err;
  logic             overrun;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic [DATA_W-1:0] sr;

  int checks;
  int errors;
  int shifts;

  serial_frame_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .ready_in   (ready_in),
    .sh_en      (sh_en),
    .frame_valid(frame_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy),
    .bit_cnt    (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream right shift register: the first bit shifted in ends at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sr <= '0;
    else if (sh_en) sr <= {serial_in, sr[DATA_W-1:1]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one line bit for one clock. Return at the next negedge, when the
  // outputs reflect the edge that sampled the bit.
  task automatic step(input logic b);
    serial_in = b;
    @(negedge clk);
    shifts += int'(sh_en);
  endtask

  // Data bits (LSB first), then the parity bit, then the stop bit.
  task automatic send_body(input logic [DATA_W-1:0] w, input logic p, input logic stop);
    for (int i = 0; i < DATA_W; i++) step(w[i]);
    step(p);
    step(stop);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] w, input logic p, input logic stop);
    shifts = 0;
    step(1'b0);
    send_body(w, p, stop);
  endtask

  task automatic release_hold();
    ready_in = 1'b1;
    step(1'b1);
    ready_in = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sh_en"}, sh_en, 0);
    chk({tag, "_valid"}, frame_valid, 0);
    chk({tag, "_perr"}, parity_err, 0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cnt"}, bit_cnt, 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    shifts    = 0;
    rst       = 1'b1;
    serial_in = 1'b1;
    ready_in  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    step(1'b1);
    chk("idle_busy", busy, 0);

    // 1: asynchronous reset after three data bits, then a clean frame.
    step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    chk("mid_cnt", bit_cnt, 3);
    chk("mid_sh_en", sh_en, 1);
    chk("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    chk("async_rst_reg", sr, 0);
    @(negedge clk);
    rst       = 1'b0;
    serial_in = 1'b1;
    step(1'b1);
    send_frame(6'b101100, 1'b1, 1'b1);
    chk("t1_valid", frame_valid, 1);
    chk("t1_perr", parity_err, 0);
    chk("t1_reg", sr, 6'b101100);
    chk("t1_sh_en", sh_en, 0);
    release_hold();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_valid", frame_valid, 0);

    // 2: data 1,0,1,1,0,0 with correct parity.
    send_frame(6'b001101, 1'b1, 1'b1);
    chk("t2_shifts", shifts, 6);
    chk("t2_valid", frame_valid, 1);
    chk("t2_perr", parity_err, 0);
    chk("t2_reg", sr, 6'b001101);
    chk("t2_cnt", bit_cnt, 6);
    release_hold();

    // 3: same data with a bad parity bit.
    send_frame(6'b001101, 1'b0, 1'b1);
    chk("t3_valid", frame_valid, 1);
    chk("t3_perr", parity_err, 1);
    release_hold();
    chk("t3_perr_idle", parity_err, 0);

    // 4: stop bit 0, line held low for 3 cycles, then it rises.
    send_frame(6'b001101, 1'b1, 1'b0);
    chk("t4_ferr", frame_err, 1);
    chk("t4_valid", frame_valid, 0);
    chk("t4_busy", busy, 1);
    step(1'b0);
    chk("t4_ferr_pulse", frame_err, 0);
    chk("t4_break_busy", busy, 1);
    step(1'b0);
    chk("t4_break_valid", frame_valid, 0);
    step(1'b1);
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_valid", frame_valid, 0);

    // 5: a start bit arrives while a word is held and not accepted.
    send_frame(6'b110010, 1'b1, 1'b1);
    chk("t5_valid", frame_valid, 1);
    step(1'b0);
    chk("t5_ovr", overrun, 1);
    chk("t5_sh_en", sh_en, 0);
    chk("t5_valid_hold", frame_valid, 1);
    step(1'b1);
    chk("t5_ovr_sticky", overrun, 1);
    chk("t5_reg", sr, 6'b110010);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    chk("t5_ovr_cleared", overrun, 0);

    // 6: back-to-back frames. ready_in and the next start bit share a cycle.
    send_frame(6'b010101, 1'b1, 1'b1);
    chk("t6a_reg", sr, 6'b010101);
    shifts   = 0;
    ready_in = 1'b1;
    step(1'b0);
    ready_in = 1'b0;
    chk("t6_to_data", sh_en, 1);
    chk("t6_valid_drop", frame_valid, 0);
    chk("t6_cnt", bit_cnt, 0);
    send_body(6'b111000, 1'b1, 1'b1);
    chk("t6b_shifts", shifts, 6);
    chk("t6b_valid", frame_valid, 1);
    chk("t6b_reg", sr, 6'b111000);
    chk("t6b_ovr", overrun, 0);
    chk("t6b_perr", parity_err, 0);
    release_hold();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
